// File: rtl/screen_transform_stream.sv
// Streams N-axis binary16 positions to clamped integer pixel coordinates.
// Stages: fp16 multiply, fp16 add, truncate/clamp, output FIFO (accept-to-FIFO latency 4).

module screen_transform_stream #(
    parameter int unsigned DIMS       = 2,
    parameter int unsigned TAG_W      = 12,
    parameter int unsigned COORD_W    = 16,
    parameter int unsigned FIFO_DEPTH = 8,
    parameter logic [DIMS*16-1:0] RESET_SCALE  = {16'h4D00, 16'h49A0},  // x 20.0, y 11.25
    parameter logic [DIMS*16-1:0] RESET_OFFSET = {16'h5900, 16'h55A0},  // x 160.0, y 90.0
    parameter logic [DIMS-1:0]    RESET_FLIP   = 2'b01,
    parameter logic [DIMS*COORD_W-1:0] SCREEN_MAX = {16'd319, 16'd179}
) (
    input  logic                    clk_in,
    input  logic                    rst_n,
    input  logic [DIMS*16-1:0]      pos_in,
    input  logic [TAG_W-1:0]        tag_in,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [DIMS*16-1:0]      cfg_scale,
    input  logic [DIMS*16-1:0]      cfg_offset,
    input  logic [DIMS-1:0]         cfg_flip,
    input  logic                    cfg_valid,
    output logic                    cfg_ready,
    output logic [DIMS*COORD_W-1:0] coord_out,
    output logic [TAG_W-1:0]        tag_out,
    output logic [DIMS-1:0]         oob_out,
    output logic                    out_valid,
    input  logic                    out_ready
);

    localparam int unsigned PW = $clog2(FIFO_DEPTH);
    localparam int unsigned EW = DIMS*COORD_W + TAG_W + DIMS;
    localparam logic [PW+1:0] DEPTH_C = (PW+2)'(FIFO_DEPTH);

    // Magnitude as fixed point with LSB weight 2^-24 (exact for all finite fp16).
    function automatic logic [39:0] to_fix(input logic [15:0] h);
        if (h[14:10] == 5'd0) return {30'b0, h[9:0]};
        return {29'b0, 1'b1, h[9:0]} << (h[14:10] - 5'd1);
    endfunction

    // Round-to-nearest-even multiply; subnormal inputs and underflowing results flush to zero.
    function automatic logic [15:0] fp16_mul(input logic [15:0] a, input logic [15:0] b);
        logic a_nan, b_nan, a_inf, b_inf, a_zero, b_zero, s, g, st;
        logic [21:0] prod;
        logic [9:0]  man;
        logic [14:0] enc;
        int e;
        s      = a[15] ^ b[15];
        a_nan  = (a[14:10] == 5'h1F) && (a[9:0] != 10'd0);
        b_nan  = (b[14:10] == 5'h1F) && (b[9:0] != 10'd0);
        a_inf  = (a[14:10] == 5'h1F) && (a[9:0] == 10'd0);
        b_inf  = (b[14:10] == 5'h1F) && (b[9:0] == 10'd0);
        a_zero = (a[14:10] == 5'd0);
        b_zero = (b[14:10] == 5'd0);
        if (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero)) return 16'h7E00;
        if (a_inf || b_inf) return {s, 15'h7C00};
        if (a_zero || b_zero) return {s, 15'h0000};
        prod = {11'b0, 1'b1, a[9:0]} * {11'b0, 1'b1, b[9:0]};
        e    = int'(a[14:10]) + int'(b[14:10]) - 15;
        if (prod[21]) begin
            man = prod[20:11];
            g   = prod[10];
            st  = |prod[9:0];
            e   = e + 1;
        end else begin
            man = prod[19:10];
            g   = prod[9];
            st  = |prod[8:0];
        end
        if (e >= 31) return {s, 15'h7C00};
        if (e <= 0) return {s, 15'h0000};
        enc = {e[4:0], man} + 15'(g & (st | man[0]));
        return {s, enc};
    endfunction

    // Exact fixed-point sum, then a single round-to-nearest-even back to fp16.
    function automatic logic [15:0] fp16_add(input logic [15:0] a, input logic [15:0] b);
        logic a_nan, b_nan, a_inf, b_inf, s, g, st;
        logic signed [41:0] fa, fb, sum;
        logic [41:0] mag;
        logic [10:0] sig;
        int p, sh;
        a_nan = (a[14:10] == 5'h1F) && (a[9:0] != 10'd0);
        b_nan = (b[14:10] == 5'h1F) && (b[9:0] != 10'd0);
        a_inf = (a[14:10] == 5'h1F) && (a[9:0] == 10'd0);
        b_inf = (b[14:10] == 5'h1F) && (b[9:0] == 10'd0);
        if (a_nan || b_nan || (a_inf && b_inf && (a[15] != b[15]))) return 16'h7E00;
        if (a_inf) return a;
        if (b_inf) return b;
        fa  = $signed({2'b00, to_fix(a)});
        fb  = $signed({2'b00, to_fix(b)});
        if (a[15]) fa = -fa;
        if (b[15]) fb = -fb;
        sum = fa + fb;
        s   = sum[41];
        mag = s ? 42'(-sum) : 42'(sum);
        p   = 0;
        for (int i = 0; i < 42; i++) if (mag[i]) p = i;
        if (p <= 10) return {s, mag[14:0]};  // exact: subnormal or smallest binade
        sh  = p - 10;
        sig = 11'(mag >> sh);
        g   = |(mag & (42'd1 << (sh - 1)));
        st  = |(mag & ((42'd1 << (sh - 1)) - 42'd1));
        if (sh >= 30) return {s, 15'h7C00};
        return {s, 15'(sh << 10) + 15'(sig) + 15'(g & (st | sig[0]))};
    endfunction

    // Returns {oob, coord}: truncate toward zero, then clamp to [0, max_v].
    function automatic logic [COORD_W:0] clamp_axis(input logic [15:0] h,
                                                    input logic [COORD_W-1:0] max_v);
        logic [15:0] ip;
        if (h[14:10] == 5'h1F) begin
            if (h[9:0] != 10'd0 || h[15]) return {1'b1, {COORD_W{1'b0}}};
            return {1'b1, max_v};
        end
        ip = 16'(to_fix(h) >> 24);
        if (h[15] && ip != 16'd0) return {1'b1, {COORD_W{1'b0}}};
        if (32'(ip) > 32'(max_v)) return {1'b1, max_v};
        return {1'b0, COORD_W'(ip)};
    endfunction

    logic [DIMS*16-1:0]      scale_q, offset_q, prod_q, prod_d, sum_q, sum_d;
    logic [DIMS-1:0]         flip_q, oob_q, oob_d;
    logic [DIMS*COORD_W-1:0] coord_q, coord_d;
    logic [TAG_W-1:0]        tag1_q, tag2_q, tag3_q;
    logic                    v1_q, v2_q, v3_q, cfg_pending_q;
    logic [PW-1:0]           wptr_q, rptr_q;
    logic [PW:0]             cnt_q;
    logic [EW-1:0]           mem [FIFO_DEPTH];
    logic [1:0]              inflight;
    logic [PW+1:0]           credits;
    logic                    accept, pop, cfg_load;

    always_comb begin
        prod_d  = '0;
        sum_d   = '0;
        coord_d = '0;
        oob_d   = '0;
        for (int i = 0; i < DIMS; i++) begin
            prod_d[16*i +: 16] = fp16_mul(pos_in[16*i +: 16] ^ {flip_q[i], 15'b0},
                                          scale_q[16*i +: 16]);
            sum_d[16*i +: 16]  = fp16_add(prod_q[16*i +: 16], offset_q[16*i +: 16]);
            {oob_d[i], coord_d[COORD_W*i +: COORD_W]} =
                clamp_axis(sum_q[16*i +: 16], SCREEN_MAX[COORD_W*i +: COORD_W]);
        end
    end

    // Credits cover every beat in flight, so the FIFO can never overflow and nothing stalls.
    always_comb begin
        inflight  = {1'b0, v1_q} + {1'b0, v2_q} + {1'b0, v3_q};
        credits   = (PW+2)'(cnt_q) + (PW+2)'(inflight);
        in_ready  = (credits < DEPTH_C) && !cfg_pending_q && !cfg_valid;
        cfg_ready = (inflight == 2'd0);
        cfg_load  = cfg_valid && cfg_ready;
        accept    = in_valid && in_ready;
        out_valid = (cnt_q != '0);
        pop       = out_valid && out_ready;
        {coord_out, tag_out, oob_out} = out_valid ? mem[rptr_q] : '0;
    end

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            scale_q       <= RESET_SCALE;
            offset_q      <= RESET_OFFSET;
            flip_q        <= RESET_FLIP;
            cfg_pending_q <= 1'b0;
            {v1_q, v2_q, v3_q}       <= '0;
            {tag1_q, tag2_q, tag3_q} <= '0;
            prod_q  <= '0;
            sum_q   <= '0;
            coord_q <= '0;
            oob_q   <= '0;
            wptr_q  <= '0;
            rptr_q  <= '0;
            cnt_q   <= '0;
        end else begin
            v1_q    <= accept;
            v2_q    <= v1_q;
            v3_q    <= v2_q;
            tag1_q  <= tag_in;
            tag2_q  <= tag1_q;
            tag3_q  <= tag2_q;
            prod_q  <= prod_d;
            sum_q   <= sum_d;
            coord_q <= coord_d;
            oob_q   <= oob_d;
            cfg_pending_q <= cfg_valid && !cfg_ready;
            if (cfg_load) begin
                scale_q  <= cfg_scale;
                offset_q <= cfg_offset;
                flip_q   <= cfg_flip;
            end
            if (v3_q) wptr_q <= wptr_q + PW'(1);
            if (pop) rptr_q <= rptr_q + PW'(1);
            cnt_q <= cnt_q + (PW+1)'(v3_q) - (PW+1)'(pop);
        end
    end

    always_ff @(posedge clk_in) begin
        if (v3_q) mem[wptr_q] <= {coord_q, tag3_q, oob_q};
    end

endmodule
